// File: rtl/stage_w.sv
`default_nettype none
// ============================================================================
// Module   : stage_w
// Purpose  : Writeback stage of the combined RISC-V/ARM 5-stage pipeline.
//            Registers the M->W bundle, formats load data, selects the
//            register-file write value and holds it steady across stalls.
//            Also qualifies the forwarding/PC-write strobes and counts
//            retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module stage_w #(
  parameter int CNT_W   = 64,
  parameter int HAS_RV  = 1,
  parameter int HAS_ARM = 1
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active low
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic [31:0]      ALUResultM,
  input  logic [31:0]      PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       LoadTypeM,
  input  logic             PCSrcM,
  input  logic             armM,
  input  logic [31:0]      ReadDataW,
  output logic [31:0]      ResultW,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             PCSrcW,
  output logic             armW,
  output logic             ValidW,
  output logic [CNT_W-1:0] InstRetW
);

  // Without RISC-V support every instruction is ARM, so the ISA flag
  // resets to 1 and stays there.
  localparam logic c_ARM_RST = (HAS_RV == 0);

  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_LINK = 2'b10;

  localparam logic [2:0] c_LT_LB  = 3'b000;
  localparam logic [2:0] c_LT_LH  = 3'b001;
  localparam logic [2:0] c_LT_LW  = 3'b010;
  localparam logic [2:0] c_LT_LBU = 3'b100;
  localparam logic [2:0] c_LT_LHU = 3'b101;

  // W pipeline registers
  logic             valid_q,      valid_d;
  logic [31:0]      alu_q,        alu_d;
  logic [31:0]      pc4_q,        pc4_d;
  logic [4:0]       rd_q,         rd_d;
  logic             regwrite_q,   regwrite_d;
  logic [1:0]       src_q,        src_d;
  logic [2:0]       lt_q,         lt_d;
  logic             pcsrc_q,      pcsrc_d;
  logic             arm_q,        arm_d;
  // stall hold register for load results
  logic             hold_valid_q, hold_valid_d;
  logic [31:0]      hold_data_q,  hold_data_d;
  // retired-instruction counter
  logic [CNT_W-1:0] instret_q,    instret_d;

  logic [2:0]       w_lt_eff;
  logic [31:0]      w_link;
  logic             w_arm_in;
  logic             w_pcsrc_en;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_fmt;
  logic             w_retire;

  // ISA-dependent datapath options resolved at elaboration time
  generate
    if (HAS_RV != 0) begin : g_rv
      assign w_lt_eff = lt_q;
      assign w_link   = pc4_q;
      assign w_arm_in = armM;
    end else begin : g_no_rv
      assign w_lt_eff = c_LT_LW;
      assign w_link   = alu_q;
      assign w_arm_in = 1'b1;
    end

    if (HAS_ARM != 0) begin : g_arm
      assign w_pcsrc_en = 1'b1;
    end else begin : g_no_arm
      assign w_pcsrc_en = 1'b0;
    end
  endgenerate

  // Sub-word lane extraction and sign/zero extension of the RAM word
  always_comb begin
    w_byte     = 8'h00;
    w_half     = alu_q[1] ? ReadDataW[31:16] : ReadDataW[15:0];
    w_load_fmt = ReadDataW;
    case (alu_q[1:0])
      2'd0:    w_byte = ReadDataW[7:0];
      2'd1:    w_byte = ReadDataW[15:8];
      2'd2:    w_byte = ReadDataW[23:16];
      default: w_byte = ReadDataW[31:24];
    endcase
    case (w_lt_eff)
      c_LT_LB:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      c_LT_LBU: w_load_fmt = {24'h000000, w_byte};
      c_LT_LH:  w_load_fmt = {{16{w_half[15]}}, w_half};
      c_LT_LHU: w_load_fmt = {16'h0000, w_half};
      default:  w_load_fmt = ReadDataW;
    endcase
  end

  // Result select; a held load value replaces the live RAM data in a stall
  always_comb begin
    ResultW = alu_q;
    case (src_q)
      c_SRC_ALU:  ResultW = alu_q;
      c_SRC_LOAD: ResultW = hold_valid_q ? hold_data_q : w_load_fmt;
      c_SRC_LINK: ResultW = w_link;
      default:    ResultW = alu_q;
    endcase
  end

  assign w_retire = valid_q & ~StallW & ~FlushW;

  // Next-state: flush beats stall beats capture; load value frozen on stall entry
  always_comb begin
    valid_d      = valid_q;
    alu_d        = alu_q;
    pc4_d        = pc4_q;
    rd_d         = rd_q;
    regwrite_d   = regwrite_q;
    src_d        = src_q;
    lt_d         = lt_q;
    pcsrc_d      = pcsrc_q;
    arm_d        = arm_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    instret_d    = instret_q + {{(CNT_W-1){1'b0}}, w_retire};
    if (FlushW) begin
      valid_d      = 1'b0;
      regwrite_d   = 1'b0;
      pcsrc_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (StallW) begin
      if (valid_q && (src_q == c_SRC_LOAD) && !hold_valid_q) begin
        hold_data_d  = w_load_fmt;
        hold_valid_d = 1'b1;
      end
    end else begin
      valid_d      = ValidM;
      alu_d        = ALUResultM;
      pc4_d        = PCPlus4M;
      rd_d         = RdM;
      regwrite_d   = RegWriteM;
      src_d        = ResultSrcM;
      lt_d         = LoadTypeM;
      pcsrc_d      = PCSrcM;
      arm_d        = w_arm_in;
      hold_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      alu_q        <= 32'h0;
      pc4_q        <= 32'h0;
      rd_q         <= 5'd0;
      regwrite_q   <= 1'b0;
      src_q        <= 2'b00;
      lt_q         <= 3'b000;
      pcsrc_q      <= 1'b0;
      arm_q        <= c_ARM_RST;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 32'h0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      pc4_q        <= pc4_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
      src_q        <= src_d;
      lt_q         <= lt_d;
      pcsrc_q      <= pcsrc_d;
      arm_q        <= arm_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      instret_q    <= instret_d;
    end
  end

  // RISC-V x0 is hard-wired zero, so such writes are dropped here
  assign RegWriteW = valid_q & regwrite_q & ~(~arm_q & (rd_q == 5'd0));
  assign PCSrcW    = valid_q & pcsrc_q & arm_q & w_pcsrc_en;
  assign RdW       = rd_q;
  assign armW      = arm_q;
  assign ValidW    = valid_q;
  assign InstRetW  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_w.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_w
// Purpose  : Self-checking bench for stage_w: directed corner cases followed
//            by randomized traffic against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_w;

  localparam int CNT_W = 6;
  localparam longint c_CNT_MASK = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             StallW, FlushW, ValidM;
  logic [31:0]      ALUResultM, PCPlus4M, ReadDataW;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic [2:0]       LoadTypeM;
  logic             PCSrcM, armM;
  logic [31:0]      ResultW;
  logic [4:0]       RdW;
  logic             RegWriteW, PCSrcW, armW, ValidW;
  logic [CNT_W-1:0] InstRetW;

  int n_checks = 0;
  int n_errors = 0;

  stage_w #(.CNT_W(CNT_W), .HAS_RV(1), .HAS_ARM(1)) dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .PCSrcM(PCSrcM), .armM(armM), .ReadDataW(ReadDataW),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .armW(armW), .ValidW(ValidW), .InstRetW(InstRetW)
  );

  always #5 clk = ~clk;

  // Instruction currently in W as seen by the model
  bit          m_valid, m_rw, m_pcs, m_arm, m_hold_v;
  logic [31:0] m_alu, m_pc4, m_hold;
  logic [4:0]  m_rd;
  logic [1:0]  m_src;
  logic [2:0]  m_lt;
  longint      m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Load value as the ISA defines it: shift the lane down, then extend
  function automatic logic [31:0] fmt(input logic [2:0] lt, input logic [31:0] addr,
                                      input logic [31:0] data);
    logic [31:0] v;
    case (lt)
      3'd0, 3'd4: begin
        v = (data >> (8 * addr[1:0])) & 32'hFF;
        if (lt == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (data >> (16 * addr[1])) & 32'hFFFF;
        if (lt == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = data;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_result();
    if (m_src == 2'b01) return m_hold_v ? m_hold : fmt(m_lt, m_alu, ReadDataW);
    if (m_src == 2'b10) return m_pc4;
    return m_alu;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_pcs = 0; m_arm = 0; m_hold_v = 0;
    m_alu = 0; m_pc4 = 0; m_hold = 0; m_rd = 0; m_src = 0; m_lt = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_valid && !StallW && !FlushW) m_cnt++;
    if (FlushW) begin
      m_valid = 0; m_rw = 0; m_pcs = 0; m_hold_v = 0;
    end else if (StallW) begin
      if (m_valid && m_src == 2'b01 && !m_hold_v) begin
        m_hold = exp_result(); m_hold_v = 1;
      end
    end else begin
      m_valid = ValidM; m_alu = ALUResultM; m_pc4 = PCPlus4M; m_rd = RdM;
      m_rw = RegWriteM; m_src = ResultSrcM; m_lt = LoadTypeM; m_pcs = PCSrcM;
      m_arm = armM; m_hold_v = 0;
    end
  endtask

  task automatic compare_all();
    chk("ResultW",   ResultW,   exp_result());
    chk("RdW",       RdW,       m_rd);
    chk("RegWriteW", RegWriteW, m_valid && m_rw && (m_arm || m_rd != 0));
    chk("PCSrcW",    PCSrcW,    m_valid && m_pcs && m_arm);
    chk("armW",      armW,      m_arm);
    chk("ValidW",    ValidW,    m_valid);
    chk("InstRetW",  InstRetW,  m_cnt & c_CNT_MASK);
  endtask

  // Inputs were set just after an edge; check, advance model, take the edge
  task automatic cycle_check();
    #1;
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit v, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [4:0] rd, input bit rw, input logic [1:0] src,
                       input logic [2:0] lt, input bit pcs, input bit arm);
    ValidM = v; ALUResultM = alu; PCPlus4M = pc4; RdM = rd; RegWriteM = rw;
    ResultSrcM = src; LoadTypeM = lt; PCSrcM = pcs; armM = arm;
  endtask

  task automatic rand_m();
    ValidM     = ($urandom_range(0, 3) != 0);
    ALUResultM = $urandom;
    PCPlus4M   = $urandom;
    RdM        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    RegWriteM  = $urandom_range(0, 1) != 0;
    ResultSrcM = 2'($urandom);
    LoadTypeM  = 3'($urandom);
    PCSrcM     = $urandom_range(0, 1) != 0;
    armM       = $urandom_range(0, 1) != 0;
  endtask

  initial begin
    longint cnt0;
    int     guard;
    rst = 1'b0; StallW = 0; FlushW = 0; ReadDataW = 32'h0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Load formatting and link result, one instruction per cycle
    set_m(1, 32'h0000_1003, 0, 5'd5, 1, 2'b01, 3'b000, 0, 0);
    cycle_check();
    ReadDataW = 32'h80FF_1234;
    set_m(1, 32'h0000_1003, 0, 5'd6, 1, 2'b01, 3'b100, 0, 0);
    #1 chk("lb", ResultW, 32'hFFFF_FF80);
    cycle_check();
    set_m(1, 32'h0000_2002, 0, 5'd7, 1, 2'b01, 3'b001, 0, 0);
    #1 chk("lbu", ResultW, 32'h0000_0080);
    cycle_check();
    ReadDataW = 32'h9ABC_0000;
    set_m(1, 32'h0000_2002, 0, 5'd8, 1, 2'b01, 3'b101, 0, 0);
    #1 chk("lh", ResultW, 32'hFFFF_9ABC);
    cycle_check();
    set_m(1, 32'h0000_2002, 0, 5'd9, 1, 2'b01, 3'b010, 0, 0);
    #1 chk("lhu", ResultW, 32'h0000_9ABC);
    cycle_check();
    set_m(1, 32'h0000_0040, 32'h0000_0104, 5'd1, 1, 2'b10, 3'b000, 0, 0);
    #1 chk("lw", ResultW, 32'h9ABC_0000);
    cycle_check();
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("jal_res", ResultW, 32'h0000_0104);
    chk("jal_we", RegWriteW, 1'b1);
    chk("jal_rd", RdW, 5'd1);
    cycle_check();

    // Load held across a 3-cycle stall while the RAM output wanders
    set_m(1, 32'h0000_3000, 0, 5'd10, 1, 2'b01, 3'b001, 0, 0);
    cycle_check();
    ReadDataW = 32'h1234_8765;
    StallW = 1;
    cnt0 = m_cnt;
    #1 chk("stall_first", ResultW, 32'hFFFF_8765);
    cycle_check();
    repeat (2) begin
      ReadDataW = $urandom;
      #1 chk("stall_hold", ResultW, 32'hFFFF_8765);
      chk("stall_nocnt", InstRetW, cnt0 & c_CNT_MASK);
      cycle_check();
    end
    StallW = 0;
    ReadDataW = $urandom;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("stall_release", ResultW, 32'hFFFF_8765);
    cycle_check();
    chk("stall_retire", InstRetW, (cnt0 + 1) & c_CNT_MASK);

    // Flush wins over stall for an ARM PC write
    set_m(1, 32'h0000_0500, 0, 5'd15, 1, 2'b00, 3'b000, 1, 1);
    cycle_check();
    #1 chk("arm_pcsrc", PCSrcW, 1'b1);
    StallW = 1; FlushW = 1;
    cnt0 = m_cnt;
    cycle_check();
    chk("flush_valid", ValidW, 1'b0);
    chk("flush_pcsrc", PCSrcW, 1'b0);
    chk("flush_we", RegWriteW, 1'b0);
    chk("flush_cnt", InstRetW, cnt0 & c_CNT_MASK);
    StallW = 0; FlushW = 0;

    // Counter wrap: run up to all-ones, then retire one more
    guard = 0;
    set_m(1, 32'h0000_0001, 0, 5'd3, 1, 2'b00, 3'b000, 0, 0);
    while (((m_cnt & c_CNT_MASK) != c_CNT_MASK || !m_valid) && guard < 500) begin
      cycle_check();
      guard++;
    end
    chk("wrap_reach", guard < 500, 1'b1);
    chk("wrap_top", InstRetW, c_CNT_MASK);
    cycle_check();
    chk("wrap_zero", InstRetW, 64'd0);

    // Asynchronous reset in the middle of a load stall
    set_m(1, 32'h0000_4001, 0, 5'd12, 1, 2'b01, 3'b000, 0, 0);
    cycle_check();
    StallW = 1;
    ReadDataW = $urandom;
    cycle_check();
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", ValidW, 1'b0);
    chk("rst_we", RegWriteW, 1'b0);
    chk("rst_pcsrc", PCSrcW, 1'b0);
    chk("rst_result", ResultW, 32'h0);
    chk("rst_rd", RdW, 5'd0);
    chk("rst_cnt", InstRetW, 64'd0);
    chk("rst_arm", armW, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    StallW = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle_check();
    chk("rst_nowrite", RegWriteW, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_m();
      StallW    = ($urandom_range(0, 3) == 0);
      FlushW    = ($urandom_range(0, 9) == 0);
      ReadDataW = $urandom;
      cycle_check();
    end
    StallW = 0; FlushW = 0;
    #1 compare_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
